data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for CPU load/store requests: the slave end of the data-memory port.
//  Accepts one request per valid/ready handshake and models LATENCY wait states.
//  Performs byte/half/word writes with per-lane enables, and sign- or zero-extends loads.
//  Returns the result over a second valid/ready handshake.
//  Sits between the CPU load/store path and on-chip word storage; a multi-cycle CPU uses it in place of combinational RAM.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words stored; power of 2, >= 2
//  LATENCY      2    wait cycles between request accept and response; 0..15
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-low reset (0 = reset)
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_size    in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_signed  in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester accepts the response
//  rsp_rdata   out  32  load result, right-aligned and extended; 0 for stores
//  rsp_err     out  1   access fault (only active with DMEM_MISALIGN_TRAP_EN)
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, RESP.
//  - Reset: FSM -> IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; all storage words cleared to 0.
//  - Reset is asynchronous and takes effect mid-transaction. An in-flight store not yet committed is dropped.
//  - req_ready = (state==IDLE), decoded from the state register; no combinational path from req_valid.
//  - IDLE: on req_valid&&req_ready, latch write/addr/wdata/size/signed.
//    - LATENCY=0: go to RESP.
//    - Otherwise: load the wait counter with LATENCY-1 and go to WAIT.
//  - WAIT: decrement the counter each cycle; at 0, go to RESP.
//  - Commit edge (the edge entering RESP):
//    - Stores write the selected lanes.
//    - Loads capture the extended result into rsp_rdata.
//  - Timing: rsp_valid rises LATENCY+1 cycles after the accept edge.
//  - RESP: rsp_valid=1. rsp_rdata/rsp_err stay stable until rsp_ready=1, then IDLE on that edge.
//  - rsp_valid deasserts in IDLE. No new request is accepted in the RESP cycle.
//  - Throughput: 1 transaction per LATENCY+2 cycles minimum.
//  - Index: word = req_addr[2 +: log2(DEPTH_WORDS)]; higher address bits are ignored (wraps modulo depth).
//  - Lanes:
//    - byte: lane addr[1:0]
//    - half: lanes {addr[1],0}+{1,0}
//    - word: all 4 lanes
//  - Loads extract the lane(s), then bit 7 (byte) or bit 15 (half) is replicated if req_signed, else zero-filled.
//  - Word loads ignore req_signed.
//  - Stores do not alter unselected lanes; rsp_rdata=0 for stores.
//  - Input changes while not in IDLE are ignored: the latched request governs.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//    - Fault cases: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
//    - A fault sets rsp_err=1, suppresses the store, and returns rsp_rdata=0.
//    - Latency is unchanged.
//  DMEM_MISALIGN_TRAP_EN undefined:
//    - rsp_err tied 0; size 11 is treated as word.
//    - half forces addr[0]=0; word forces addr[1:0]=0, i.e. silently aligned.
// TESTING
//  1. Reset with rst=0 mid-WAIT of a store to 0x10 -> busy=0 and rsp_valid=0 immediately; later word load 0x10 returns 0.
//  2. LATENCY=2: word store 0xDEADBEEF @0x20, then word load @0x20 -> 0xDEADBEEF. rsp_valid is seen 3 cycles after each accept.
//  3. byte store 0x80 @0x21, then byte load signed @0x21 -> 0xFFFFFF80; unsigned -> 0x00000080.
//     Word @0x20 then reads 0xDEAD80EF.
//  4. half load signed @0x22 after step 3 -> 0xFFFFDEAD.
//     Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout.
//  5. Address wrap: DEPTH_WORDS=256, word store 0x1234 @0x400 -> word load @0x0 returns 0x00001234.
//  6. Word store 0xCAFEF00D @0x33:
//     - With DMEM_MISALIGN_TRAP_EN: rsp_err=1 and word @0x30 is unchanged.
//     - Without it: the store lands at 0x30 and rsp_err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, LATENCY wait states, lane-masked stores, extended loads.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            accept;
    logic            commit;

    logic            lat_write;
    logic            lat_signed;
    logic [AW+1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic [1:0]      lat_size;

    logic            eff_write;
    logic            eff_signed;
    logic [AW+1:0]   eff_addr;
    logic [31:0]     eff_wdata;
    logic [1:0]      eff_size;

    logic [1:0]      acc_size;
    logic [1:0]      lane_off;
    logic [3:0]      lane_mask;
    logic            fault;
    logic [AW-1:0]   word_idx;
    logic [31:0]     wdata_rep;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     load_val;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            unused_bits;
    assign unused_bits = ^{req_addr[31:AW+2], rd_shift[31:16]};

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
        logic signed [31:0] s;
        s = $signed(b);
        return sgn ? s : {24'd0, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sgn);
        logic signed [31:0] s;
        s = $signed(h);
        return sgn ? s : {16'd0, h};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    assign accept = (state == IDLE) && req_valid;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    assign commit = (state_nxt == RESP) && (state != RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           cnt <= 4'd0;
        else if (accept)                    cnt <= CNT_INIT;
        else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write  <= req_write;
            lat_signed <= req_signed;
            lat_addr   <= req_addr[AW+1:0];
            lat_wdata  <= req_wdata;
            lat_size   <= req_size;
        end
    end

    // With LATENCY=0 the commit happens on the accept edge, so the live request is used in IDLE
    always_comb begin
        if (state == IDLE) begin
            eff_write  = req_write;
            eff_signed = req_signed;
            eff_addr   = req_addr[AW+1:0];
            eff_wdata  = req_wdata;
            eff_size   = req_size;
        end else begin
            eff_write  = lat_write;
            eff_signed = lat_signed;
            eff_addr   = lat_addr;
            eff_wdata  = lat_wdata;
            eff_size   = lat_size;
        end
    end

    always_comb begin
        word_idx = eff_addr[2 +: AW];
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_size = eff_size;
        lane_off = eff_addr[1:0];
        fault    = (eff_size == 2'b01 && eff_addr[0]) ||
                   (eff_size == 2'b10 && eff_addr[1:0] != 2'b00) ||
                   (eff_size == 2'b11);
`else
        acc_size = (eff_size == 2'b11) ? 2'b10 : eff_size;
        fault    = 1'b0;
        case (acc_size)
            2'b00:   lane_off = eff_addr[1:0];
            2'b01:   lane_off = {eff_addr[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
`endif
        case (acc_size)
            2'b00: begin
                lane_mask = 4'b0001 << lane_off;
                wdata_rep = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << lane_off;
                wdata_rep = {2{eff_wdata[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                wdata_rep = eff_wdata;
            end
        endcase
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {lane_off, 3'b000};
        case (acc_size)
            2'b00:   load_val = extend_byte(rd_shift[7:0], eff_signed);
            2'b01:   load_val = extend_half(rd_shift[15:0], eff_signed);
            default: load_val = rd_word;
        endcase
    end

    // Response registers capture on the edge entering RESP and hold until the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (eff_write || fault) ? 32'd0 : load_val;
            rsp_err   <= fault;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (commit && eff_write && !fault) begin
            for (int l = 0; l < 4; l++)
                if (lane_mask[l]) mem[word_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model, per-cycle compare, directed literal checks.
// Expectations adapt to DMEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_data_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int          checks = 0;
    int          errors = 0;
    logic        in_flight = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err = 1'b0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] got;
    logic        gerr;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic m_fault(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (sz == 2'd1 && a % 2 == 1) || (sz == 2'd2 && a % 4 != 0) || sz == 2'd3;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Bytes are picked out arithmetically; signedness is applied by subtracting 2^N
    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        longint w = longint'(mem_m[m_idx(a)]);
        int     k = int'(a % 4);
        longint v;
        case (sz)
            2'd0: begin
                v = (w >> (8 * k)) & 255;
                if (sg && v >= 128) v = v - 256;
            end
            2'd1: begin
                k = k - k % 2;
                v = (w >> (8 * k)) & 65535;
                if (sg && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int     idx = m_idx(a);
        longint w   = longint'(mem_m[idx]);
        longint dv  = longint'(d);
        int     k   = int'(a % 4);
        int     n;
        case (sz)
            2'd0:    n = 1;
            2'd1:    begin n = 2; k = k - k % 2; end
            default: begin n = 4; k = 0; end
        endcase
        for (int j = 0; j < n; j++) begin
            longint bv = (dv >> (8 * j)) & 255;
            w = (w & ~(longint'(255) << (8 * (k + j)))) | (bv << (8 * (k + j)));
        end
        mem_m[idx] = w[31:0];
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    endfunction

    // Per-cycle compare against the model's view of the transaction
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, !in_flight});
            check("busy", {31'd0, busy}, {31'd0, in_flight});
            if (!in_flight) check("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
            if (rsp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            end
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg, input int hold,
                       input logic chk_lit, input logic [31:0] lit, input logic lit_err,
                       output logic [31:0] r, output logic e);
        int n;
        @(negedge clk);
        req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_signed = sg;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            r = 32'd0; e = 1'b0;
            return;
        end
        exp_err   = m_fault(a, sz);
        exp_rdata = (w || exp_err) ? 32'd0 : m_load(a, sz, sg);
        @(posedge clk);
        in_flight = 1'b1;
        #1;
        req_valid = 1'b0;
        req_write = ~w; req_addr = ~a; req_wdata = ~d; req_size = ~sz; req_signed = ~sg;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        check("rsp_latency", n, LATENCY + 1);
        repeat (hold) @(negedge clk);
        r = rsp_rdata;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        in_flight = 1'b0;
        if (w && !exp_err) m_store(a, d, sz);
        #1 rsp_ready = 1'b0;
        if (chk_lit) begin
            check("lit_rdata", r, lit);
            check("lit_err", {31'd0, e}, {31'd0, lit_err});
        end
    endtask

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic [31:0] LIT_W30  = 32'h11223344;
    localparam logic        LIT_E33  = 1'b1;
    localparam logic [31:0] LIT_SZ3  = 32'h00000000;
    localparam logic        LIT_E3   = 1'b1;
    localparam logic [31:0] LIT_H23  = 32'h00000000;
`else
    localparam logic [31:0] LIT_W30  = 32'hCAFEF00D;
    localparam logic        LIT_E33  = 1'b0;
    localparam logic [31:0] LIT_SZ3  = 32'hCAFEF00D;
    localparam logic        LIT_E3   = 1'b0;
    localparam logic [31:0] LIT_H23  = 32'hFFFFDEAD;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = 2'd0; req_signed = 1'b0; rsp_ready = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a store's wait states
        txn(1'b1, 32'h10, 32'h55, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0, got, gerr);
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h77; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        in_flight = 1'b1;
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        in_flight = 1'b0;
        m_clear();
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h00000000, 1'b0, got, gerr);

        // Word, byte and half accesses around 0x20
        txn(1'b1, 32'h20, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0, got, gerr);
        txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, got, gerr);
        txn(1'b1, 32'h21, 32'h80, 2'd0, 1'b0, 0, 1'b1, 32'h0, 1'b0, got, gerr);
        txn(1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'hFFFFFF80, 1'b0, got, gerr);
        txn(1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 0, 1'b1, 32'h00000080, 1'b0, got, gerr);
        txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'hDEAD80EF, 1'b0, got, gerr);
        txn(1'b0, 32'h22, 32'h0, 2'd1, 1'b1, 5, 1'b1, 32'hFFFFDEAD, 1'b0, got, gerr);
        txn(1'b0, 32'h20, 32'h0, 2'd1, 1'b0, 2, 1'b1, 32'h000080EF, 1'b0, got, gerr);
        txn(1'b0, 32'h20, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'hFFFFFFEF, 1'b0, got, gerr);
        txn(1'b0, 32'h23, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'hFFFFFFDE, 1'b0, got, gerr);
        txn(1'b0, 32'h22, 32'h0, 2'd2, 1'b1, 0, 1'b0, 32'h0, 1'b0, got, gerr);

        // Address wrap modulo depth
        txn(1'b1, 32'h400, 32'h00001234, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0, got, gerr);
        txn(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h00001234, 1'b0, got, gerr);
        txn(1'b1, 32'h402, 32'h5555ABCD, 2'd1, 1'b0, 0, 1'b1, 32'h0, 1'b0, got, gerr);
        txn(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'hABCD1234, 1'b0, got, gerr);

        // Misaligned and reserved-size accesses
        txn(1'b1, 32'h30, 32'h11223344, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0, got, gerr);
        txn(1'b1, 32'h33, 32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b1, 32'h0, LIT_E33, got, gerr);
        txn(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, 1'b1, LIT_W30, 1'b0, got, gerr);
        txn(1'b0, 32'h30, 32'h0, 2'd3, 1'b0, 0, 1'b1, LIT_SZ3, LIT_E3, got, gerr);
        txn(1'b0, 32'h23, 32'h0, 2'd1, 1'b1, 0, 1'b1, LIT_H23, LIT_E3, got, gerr);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
